// File: rtl/sevenseg_capture.sv
// Seven-segment bus monitor: filters scan glitches, decodes stable digit
// patterns back to BCD and delivers one word per complete scan frame.
module sevenseg_capture #(
  parameter int NDIG   = 4,
  parameter int STABLE = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [6:0]          seg_in,
  input  logic [NDIG-1:0]     dig_en,
  output logic [4*NDIG-1:0]   out_bcd,
  output logic                out_err,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                overrun
);

  typedef enum logic {COLLECT, DONE} state_e;

  localparam int          IW       = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [3:0]  STABLE_C = 4'(STABLE);

  // Returns {invalid, code}; blank decodes to F without flagging an error.
  function automatic logic [4:0] decode(input logic [6:0] seg);
    case (seg)
      7'h7E:   decode = {1'b0, 4'd0};
      7'h30:   decode = {1'b0, 4'd1};
      7'h6D:   decode = {1'b0, 4'd2};
      7'h79:   decode = {1'b0, 4'd3};
      7'h33:   decode = {1'b0, 4'd4};
      7'h5B:   decode = {1'b0, 4'd5};
      7'h5F:   decode = {1'b0, 4'd6};
      7'h70:   decode = {1'b0, 4'd7};
      7'h7F:   decode = {1'b0, 4'd8};
      7'h7B:   decode = {1'b0, 4'd9};
      7'h00:   decode = {1'b0, 4'hF};
      default: decode = {1'b1, 4'hE};
    endcase
  endfunction

  logic [6:0]        s_seg_q;
  logic [NDIG-1:0]   s_en_q;
  logic [3:0]        cnt_q, cnt_d;
  logic [3:0]        n_set;
  logic [IW-1:0]     cap_idx;
  logic              en_onehot, en_same, capture;
  logic [3:0]        cap_code;
  logic              cap_inv;

  logic [NDIG-1:0]   mask_q, mask_d;
  logic              frame_err_q, frame_err_d;
  logic [4*NDIG-1:0] slots_q;

  state_e            state_q, state_d;
  logic              frame_done;

  logic              out_valid_q, out_valid_d;
  logic [4*NDIG-1:0] out_bcd_q, out_bcd_d;
  logic              out_err_q, out_err_d;
  logic              overrun_q, overrun_d;

  // NOTE: every combinational output gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    n_set   = '0;
    cap_idx = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (dig_en[i]) begin
        n_set   = n_set + 4'd1;
        cap_idx = IW'(i);
      end
    end
  end

  assign en_onehot = (n_set == 4'd1);
  assign en_same   = en_onehot && (dig_en == s_en_q) && (seg_in == s_seg_q);
  assign {cap_inv, cap_code} = decode(seg_in);

  always_comb begin
    cnt_d = 4'd0;
    if (en_same) begin
      cnt_d = (cnt_q >= STABLE_C) ? STABLE_C : cnt_q + 4'd1;
    end else if (en_onehot) begin
      cnt_d = 4'd1;
    end
  end

  // A saturated hold must not recapture; a fresh pattern reaching STABLE does.
  assign capture = (cnt_d == STABLE_C) && !(en_same && (cnt_q == STABLE_C));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_seg_q <= '0;
      s_en_q  <= '0;
      cnt_q   <= '0;
    end else begin
      s_seg_q <= seg_in;
      s_en_q  <= dig_en;
      cnt_q   <= cnt_d;
    end
  end

  // A capture on the DONE edge starts the next frame.
  always_comb begin
    mask_d      = frame_done ? '0 : mask_q;
    frame_err_d = frame_done ? 1'b0 : frame_err_q;
    if (capture) begin
      mask_d[cap_idx] = 1'b1;
      frame_err_d     = frame_err_d | cap_inv;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q      <= '0;
      frame_err_q <= 1'b0;
    end else begin
      mask_q      <= mask_d;
      frame_err_q <= frame_err_d;
    end
  end

  // NOTE: digit slots are not reset; a cleared mask forces every slot to be rewritten before a frame is released.
  always_ff @(posedge clk) begin
    if (capture) begin
      slots_q[4*int'(cap_idx) +: 4] <= cap_code;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= COLLECT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      COLLECT: if (&mask_d) state_d = DONE;
      DONE:    state_d = COLLECT;
      default: state_d = COLLECT;
    endcase
  end

  always_comb begin
    frame_done = (state_q == DONE);
  end

  // One-entry buffer: a completed frame replaces the entry only if it is empty or being popped.
  always_comb begin
    out_valid_d = out_valid_q;
    out_bcd_d   = out_bcd_q;
    out_err_d   = out_err_q;
    overrun_d   = 1'b0;
    if (frame_done) begin
      if (!out_valid_q || out_ready) begin
        out_valid_d = 1'b1;
        out_bcd_d   = slots_q;
        out_err_d   = frame_err_q;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_bcd_q   <= '0;
      out_err_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_bcd_q   <= out_bcd_d;
      out_err_q   <= out_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_bcd   = out_bcd_q;
  assign out_err   = out_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_sevenseg_capture.sv
// Bench for sevenseg_capture: directed scans plus random scans, compared each
// cycle against a frame-level reference model driven from the scan schedule.
module tb_sevenseg_capture;

  localparam int NDIG   = 4;
  localparam int STABLE = 3;

  logic                clk = 1'b0;
  logic                rst;
  logic [6:0]          seg_in;
  logic [NDIG-1:0]     dig_en;
  logic [4*NDIG-1:0]   out_bcd;
  logic                out_err;
  logic                out_valid;
  logic                out_ready;
  logic                overrun;

  sevenseg_capture #(.NDIG(NDIG), .STABLE(STABLE)) dut (
    .clk       (clk),
    .rst       (rst),
    .seg_in    (seg_in),
    .dig_en    (dig_en),
    .out_bcd   (out_bcd),
    .out_err   (out_err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  // Digit patterns 0..9 in order, then blank and one invalid pattern.
  logic [6:0] pat_tbl [12] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B,
                               7'h5F, 7'h70, 7'h7F, 7'h7B, 7'h00, 7'h01};

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int ov_cnt = 0;

  bit              rdy_rand = 1'b0;
  logic            rdy_hold = 1'b1;
  logic [NDIG-1:0] last_en  = '0;
  logic [6:0]      last_pat = '0;
  bit              any_valid;

  // Reference model state: frame under assembly plus the output buffer.
  logic [4*NDIG-1:0] m_slots = '0;
  logic [NDIG-1:0]   m_mask  = '0;
  logic              m_ferr  = 1'b0;
  bit                m_done_pend = 1'b0;
  logic              m_valid = 1'b0;
  logic [4*NDIG-1:0] m_bcd   = '0;
  logic              m_err   = 1'b0;
  logic              m_ovr   = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s @cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic bit is_onehot(input logic [NDIG-1:0] en);
    return $countones(en) == 1;
  endfunction

  function automatic logic [4:0] ref_decode(input logic [6:0] p);
    for (int k = 0; k < 10; k++) begin
      if (pat_tbl[k] == p) return {1'b0, 4'(k)};
    end
    if (p == 7'h00) return {1'b0, 4'hF};
    return {1'b1, 4'hE};
  endfunction

  task automatic model_edge(input logic r, input bit cap, input logic [NDIG-1:0] en,
                            input logic [6:0] pat, input logic rdy);
    bit         do_done;
    logic [4:0] d;
    int         idx;
    if (r) begin
      m_mask = '0; m_ferr = 1'b0; m_done_pend = 1'b0;
      m_valid = 1'b0; m_bcd = '0; m_err = 1'b0; m_ovr = 1'b0;
      return;
    end
    do_done = m_done_pend;
    m_ovr   = 1'b0;
    if (do_done) begin
      if (!m_valid || rdy) begin
        m_valid = 1'b1; m_bcd = m_slots; m_err = m_ferr;
      end else begin
        m_ovr = 1'b1;
      end
      m_mask = '0; m_ferr = 1'b0;
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    if (cap) begin
      idx = 0;
      for (int i = 0; i < NDIG; i++) if (en[i]) idx = i;
      d = ref_decode(pat);
      m_slots[4*idx +: 4] = d[3:0];
      m_mask[idx] = 1'b1;
      m_ferr = m_ferr | d[4];
    end
    m_done_pend = !do_done && (m_mask == {NDIG{1'b1}});
  endtask

  task automatic step(input logic r, input logic [NDIG-1:0] en, input logic [6:0] pat, input bit cap);
    rst       = r;
    dig_en    = en;
    seg_in    = pat;
    out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_hold;
    @(posedge clk);
    cyc++;
    model_edge(r, cap, en, pat, out_ready);
    last_en  = r ? '0 : en;
    last_pat = r ? '0 : pat;
    #1;
    if (overrun) ov_cnt++;
    if (out_valid) any_valid = 1'b1;
    check("valid",   32'(out_valid), 32'(m_valid));
    check("overrun", 32'(overrun),   32'(m_ovr));
    check("bcd",     32'(out_bcd),   32'(m_bcd));
    check("err",     32'(out_err),   32'(m_err));
  endtask

  // Holds one pattern on one enable for len cycles; j0>0 continues an earlier hold.
  task automatic drive_seg(input logic [NDIG-1:0] en, input logic [6:0] pat, input int len, input int j0);
    logic [6:0] p;
    p = pat;
    if (j0 == 0 && is_onehot(en) && en == last_en && p == last_pat) p = p ^ 7'h08;
    for (int j = 0; j < len; j++) step(1'b0, en, p, is_onehot(en) && (j0 + j == STABLE - 1));
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) step(1'b0, '0, '0, 1'b0);
  endtask

  task automatic frame(input logic [6:0] p0, input logic [6:0] p1, input logic [6:0] p2, input logic [6:0] p3);
    drive_seg(4'b0001, p0, 4, 0);
    drive_seg(4'b0010, p1, 4, 0);
    drive_seg(4'b0100, p2, 4, 0);
    drive_seg(4'b1000, p3, 4, 0);
  endtask

  initial begin
    int ov0;
    logic [NDIG-1:0] en;
    logic [6:0]      p;
    int              sel;

    // Reset with random inputs, then idle.
    for (int k = 0; k < 2; k++) step(1'b1, NDIG'($urandom), 7'($urandom), 1'b0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_bcd",   32'(out_bcd),   32'd0);
    check("rst_err",   32'(out_err),   32'd0);
    check("rst_ovr",   32'(overrun),   32'd0);
    any_valid = 1'b0;
    idle(10);
    check("idle_valid", 32'(any_valid), 32'd0);

    // Basic frame: 5,1,8,0 with valid three edges after digit3 appears.
    rdy_hold = 1'b1;
    drive_seg(4'b0001, 7'h5B, 4, 0);
    drive_seg(4'b0010, 7'h30, 4, 0);
    drive_seg(4'b0100, 7'h7F, 4, 0);
    drive_seg(4'b1000, 7'h7E, 3, 0);
    check("basic_early", 32'(out_valid), 32'd0);
    drive_seg(4'b1000, 7'h7E, 1, 3);
    check("basic_valid", 32'(out_valid), 32'd1);
    check("basic_bcd",   32'(out_bcd),   32'h0815);
    check("basic_err",   32'(out_err),   32'd0);

    // Glitch filter: short holds and a two-hot enable never capture.
    idle(1);
    any_valid = 1'b0;
    for (int s = 0; s < 3; s++) begin
      drive_seg(4'b0001, 7'h30, 2, 0);
      drive_seg(4'b0010, 7'h6D, 2, 0);
      drive_seg(4'b0100, 7'h79, 2, 0);
      drive_seg(4'b1000, 7'h33, 2, 0);
    end
    drive_seg(4'b0011, 7'h7E, 10, 0);
    idle(4);
    check("glitch_valid", 32'(any_valid), 32'd0);

    // Decode coverage over three frames.
    frame(7'h7E, 7'h30, 7'h6D, 7'h79);
    check("dec_a_bcd", 32'(out_bcd), 32'h3210);
    check("dec_a_err", 32'(out_err), 32'd0);
    frame(7'h33, 7'h5B, 7'h5F, 7'h70);
    check("dec_b_bcd", 32'(out_bcd), 32'h7654);
    check("dec_b_err", 32'(out_err), 32'd0);
    frame(7'h7F, 7'h7B, 7'h00, 7'h01);
    check("dec_c_bcd", 32'(out_bcd), 32'hEF98);
    check("dec_c_err", 32'(out_err), 32'd1);

    // Backpressure: second frame dropped with a single overrun pulse.
    idle(1);
    rdy_hold = 1'b0;
    ov0 = ov_cnt;
    frame(7'h30, 7'h6D, 7'h79, 7'h33);
    check("bp_f1_valid", 32'(out_valid), 32'd1);
    check("bp_f1_bcd",   32'(out_bcd),   32'h4321);
    frame(7'h5B, 7'h5F, 7'h70, 7'h7F);
    check("bp_ovr_now",  32'(overrun),   32'd1);
    check("bp_hold_bcd", 32'(out_bcd),   32'h4321);
    idle(3);
    check("bp_ovr_cnt",  32'(ov_cnt - ov0), 32'd1);
    drive_seg(4'b0001, 7'h7B, 4, 0);
    drive_seg(4'b0010, 7'h7B, 4, 0);
    drive_seg(4'b0100, 7'h7B, 4, 0);
    drive_seg(4'b1000, 7'h30, 3, 0);
    rdy_hold = 1'b1;
    drive_seg(4'b1000, 7'h30, 1, 3);
    check("bp_f3_valid", 32'(out_valid), 32'd1);
    check("bp_f3_bcd",   32'(out_bcd),   32'h1999);
    check("bp_ovr_cnt2", 32'(ov_cnt - ov0), 32'd1);

    // Mid-frame reset discards partial captures.
    idle(1);
    drive_seg(4'b0001, 7'h7B, 4, 0);
    drive_seg(4'b0010, 7'h7B, 4, 0);
    drive_seg(4'b0100, 7'h7B, 4, 0);
    step(1'b1, 4'b0100, 7'h7B, 1'b0);
    check("mr_valid", 32'(out_valid), 32'd0);
    any_valid = 1'b0;
    drive_seg(4'b1000, 7'h33, 4, 0);
    idle(4);
    check("mr_no_stale", 32'(any_valid), 32'd0);
    drive_seg(4'b0001, 7'h30, 4, 0);
    drive_seg(4'b0010, 7'h6D, 4, 0);
    drive_seg(4'b0100, 7'h79, 4, 0);
    check("mr_valid2", 32'(out_valid), 32'd1);
    check("mr_bcd",    32'(out_bcd),   32'h4321);

    // Random scans with random backpressure and occasional reset.
    rdy_rand = 1'b1;
    for (int s = 0; s < 400; s++) begin
      if ($urandom_range(0, 49) == 0) step(1'b1, NDIG'($urandom), 7'($urandom), 1'b0);
      sel = $urandom_range(0, 9);
      if (sel == 0)      en = '0;
      else if (sel == 1) en = NDIG'($urandom);
      else               en = NDIG'(1) << $urandom_range(0, NDIG - 1);
      if ($urandom_range(0, 9) < 7) p = pat_tbl[$urandom_range(0, 11)];
      else                          p = 7'($urandom);
      drive_seg(en, p, $urandom_range(1, 6), 0);
    end
    rdy_rand = 1'b0;
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
